// File: rtl/blink_pkg.sv
// Shared constants, FSM encoding and cipher round helpers for the Blink stream controller.
package blink_pkg;

   localparam int BLK_W      = 128;
   localparam int TWK_W      = 256;
   localparam int ROUNDS     = 20;
   localparam int KEY_W      = 1280;
   localparam int KEY_RND    = KEY_W / BLK_W;
   localparam int FIFO_DEPTH = 4;
   localparam int CTR_W      = 64;
   localparam int PTR_W      = $clog2(FIFO_DEPTH);
   localparam int CNT_W      = PTR_W + 1;
   localparam int ROT        = 7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   function automatic logic [BLK_W-1:0] rotl(input logic [BLK_W-1:0] x);
      return {x[BLK_W-1-ROT:0], x[BLK_W-1:BLK_W-ROT]};
   endfunction

   function automatic logic [BLK_W-1:0] rotr(input logic [BLK_W-1:0] x);
      return {x[ROT-1:0], x[BLK_W-1:ROT]};
   endfunction

   // Round r mixes key slot r mod 10 with the low tweak half on even rounds, high half on odd.
   function automatic logic [BLK_W-1:0] round_key(input logic [KEY_W-1:0] key,
                                                 input logic [TWK_W-1:0] tweak,
                                                 input int r);
      logic [BLK_W-1:0] half;
      if (r[0] == 1'b0) begin
         half = tweak[BLK_W-1:0];
      end else begin
         half = tweak[TWK_W-1:BLK_W];
      end
      return key[(r % KEY_RND) * BLK_W +: BLK_W] ^ half;
   endfunction

endpackage

// File: rtl/Blink_top.sv
// Combinational tweakable block cipher core: 20 add-rotate-xor rounds, decrypt runs them inverted
// in reverse order.
module Blink_top
   import blink_pkg::*;
(
   input  logic             enc,
   input  logic [KEY_W-1:0] key,
   input  logic [TWK_W-1:0] tweak,
   input  logic [BLK_W-1:0] din,
   output logic [BLK_W-1:0] dout
);

   logic [BLK_W-1:0] x_s;

   // Encrypt round: x = rotl(x + t) ^ t; decrypt round: x = rotr(x ^ t) - t.
   always_comb begin
      x_s = din;
      for (int i = 0; i < ROUNDS; i++) begin
         if (enc) begin
            x_s = rotl(x_s + round_key(key, tweak, i)) ^ round_key(key, tweak, i);
         end else begin
            x_s = rotr(x_s ^ round_key(key, tweak, ROUNDS - 1 - i)) - round_key(key, tweak, ROUNDS - 1 - i);
         end
      end
      dout = x_s;
   end

endmodule

// File: rtl/blink_stream_ctrl.sv
// Streaming wrapper around Blink_top: stage register, 4-entry output FIFO, IDLE/RUN/DRAIN FSM.
// Optional per-block tweak counter enabled by macro BLINK_STREAM_TWEAK_CTR_EN.
module blink_stream_ctrl
   import blink_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_enc,
   input  logic [KEY_W-1:0] cfg_key,
   input  logic [TWK_W-1:0] cfg_tweak,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BLK_W-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BLK_W-1:0] out_data,
   output logic             out_last,
   output logic             busy
);

   state_t           state_r, state_nxt_s;
   logic             enc_r;
   logic [KEY_W-1:0] key_r;
   logic [TWK_W-1:0] base_r;
   logic             stage_valid_r, stage_last_r;
   logic [BLK_W-1:0] stage_data_r;
   logic [TWK_W-1:0] stage_tweak_r;
   logic [BLK_W:0]   fifo_mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
   logic [CNT_W-1:0] count_r, count_nxt_s;
   logic             accept_s, pop_s, start_s;
   logic [TWK_W-1:0] blk_tweak_s;
   logic [BLK_W-1:0] core_out_s;

   assign accept_s = in_valid && in_ready;
   assign pop_s    = out_valid && out_ready;
   assign start_s  = accept_s && (state_r == ST_IDLE);

   // The stage register always drains into the FIFO: in_ready keeps count + stage below depth.
   always_comb begin
      count_nxt_s = count_r + {{(CNT_W-1){1'b0}}, stage_valid_r} - {{(CNT_W-1){1'b0}}, pop_s};
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state; a single-block message goes straight to DRAIN.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nxt_s = in_last ? ST_DRAIN : ST_RUN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (accept_s && in_last) begin
               state_nxt_s = ST_DRAIN;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (!stage_valid_r && (count_nxt_s == {CNT_W{1'b0}})) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM and FIFO outputs.
   always_comb begin
      busy      = (state_r != ST_IDLE);
      in_ready  = (state_r != ST_DRAIN) &&
                  ((count_r + {{(CNT_W-1){1'b0}}, stage_valid_r}) < CNT_W'(FIFO_DEPTH));
      out_valid = (count_r != {CNT_W{1'b0}});
      out_data  = fifo_mem_r[rd_ptr_r][BLK_W-1:0];
      out_last  = fifo_mem_r[rd_ptr_r][BLK_W];
   end

   // Message configuration captured on the first accepted block only.
   always_ff @(posedge clk) begin
      if (!rst) begin
         enc_r  <= 1'b0;
         key_r  <= {KEY_W{1'b0}};
         base_r <= {TWK_W{1'b0}};
      end else if (start_s) begin
         enc_r  <= cfg_enc;
         key_r  <= cfg_key;
         base_r <= cfg_tweak;
      end else begin
         enc_r  <= enc_r;
         key_r  <= key_r;
         base_r <= base_r;
      end
   end

`ifdef BLINK_STREAM_TWEAK_CTR_EN
   logic [CTR_W-1:0] idx_r;

   // Block index within the message; the first block uses idx 0 straight from cfg_tweak.
   always_ff @(posedge clk) begin
      if (!rst) begin
         idx_r <= {CTR_W{1'b0}};
      end else if (accept_s) begin
         idx_r <= start_s ? {{(CTR_W-1){1'b0}}, 1'b1} : idx_r + {{(CTR_W-1){1'b0}}, 1'b1};
      end else begin
         idx_r <= idx_r;
      end
   end

   always_comb begin
      if (state_r == ST_IDLE) begin
         blk_tweak_s = cfg_tweak;
      end else begin
         blk_tweak_s = {base_r[TWK_W-1:CTR_W], base_r[CTR_W-1:0] + idx_r};
      end
   end
`else
   always_comb begin
      if (state_r == ST_IDLE) begin
         blk_tweak_s = cfg_tweak;
      end else begin
         blk_tweak_s = base_r;
      end
   end
`endif

   // Stage register: accepted block paired with its tweak.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stage_valid_r <= 1'b0;
         stage_last_r  <= 1'b0;
         stage_data_r  <= {BLK_W{1'b0}};
         stage_tweak_r <= {TWK_W{1'b0}};
      end else begin
         stage_valid_r <= accept_s;
         if (accept_s) begin
            stage_last_r  <= in_last;
            stage_data_r  <= in_data;
            stage_tweak_r <= blk_tweak_s;
         end
      end
   end

   Blink_top u_core (
      .enc   (enc_r),
      .key   (key_r),
      .tweak (stage_tweak_r),
      .din   (stage_data_r),
      .dout  (core_out_s)
   );

   // Output FIFO: push from the stage register, pop on handshake, both allowed together.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem_r[i] <= {(BLK_W+1){1'b0}};
         end
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (stage_valid_r) begin
            fifo_mem_r[wr_ptr_r] <= {stage_last_r, core_out_s};
            wr_ptr_r             <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
         end
         count_r <= count_nxt_s;
      end
   end

endmodule

// File: doc/blink_stream_ctrl.md
BLINK_STREAM_CTRL -- requirements
Module: blink_stream_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: cfg_enc  in  1  1=encrypt, 0=decrypt; sampled at message start.
REQ-004 SHALL have ports: cfg_key  in  1280  round keys (128 x 10); sampled at message start.
REQ-005 SHALL have ports: cfg_tweak  in  256  tweak base; sampled at message start.
REQ-006 SHALL have ports: in_valid/in_ready  in/out  1/1  input block handshake.
REQ-007 SHALL have ports: in_data  in  128  plaintext/ciphertext block; in_last  in  1  final block of message.
REQ-008 SHALL have ports: out_valid/out_ready  out/in  1/1  output block handshake.
REQ-009 SHALL have ports: out_data  out  128  cipher result; out_last  out  1  copy of in_last of same block.
REQ-010 SHALL have ports: busy  out  1  high whenever state != IDLE.

Function
REQ-011 SHALL transfer a block only when valid and ready are both high at a rising edge; blocks SHALL leave in acceptance order.
REQ-012 SHALL implement FSM states IDLE, RUN, DRAIN: IDLE->RUN on first accepted block; RUN->DRAIN on accepted block with in_last=1; DRAIN->IDLE when stage register and FIFO are empty.
REQ-013 SHALL, on an IDLE->RUN acceptance, capture cfg_enc, cfg_key and cfg_tweak; cfg changes during RUN/DRAIN SHALL be ignored.
REQ-014 SHALL form each block tweak as {base[255:64], base[63:0] + idx}, idx = 0 for the first block, +1 per accepted block, mod 2^64 (wrap to 0, upper 192 bits unchanged).
REQ-015 SHALL pipeline: accepted block registered with its tweak into a stage register; one Blink_top evaluation; result written to a 4-entry output FIFO at the next edge.
REQ-016 SHALL give minimum latency 2: block accepted in cycle N -> out_valid in cycle N+2 when the FIFO is empty.
REQ-017 SHALL drive in_ready = (state != DRAIN) && (fifo_count + stage_valid < 4); in_ready SHALL NOT depend combinationally on in_valid.
REQ-018 SHALL allow simultaneous FIFO push and pop in one cycle with count unchanged; a full FIFO with out_ready=1 SHALL accept a push in that cycle only if in_ready allowed the feeding acceptance.
REQ-019 SHALL hold out_data/out_last stable while out_valid=1 and out_ready=0.
REQ-020 SHALL sustain one block per cycle when out_ready is held high.

Reset
REQ-021 SHALL, at a rising edge with rst=0, clear state to IDLE, FIFO pointers/count, stage_valid, idx and captured config to 0.
REQ-022 SHALL present after reset: in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0.
REQ-023 SHALL discard all in-flight and buffered blocks on reset mid-message; no output of a discarded block SHALL appear afterwards.

Configuration
REQ-024 SHALL honour macro BLINK_STREAM_TWEAK_CTR_EN: defined -> tweak per REQ-014; undefined -> every block uses captured base unchanged and idx counter logic SHALL be absent.

Structure
REQ-025 SHALL take shared constants from package blink_pkg: block width 128, tweak width 256, rounds 20, key width 1280, FIFO depth 4, counter width 64.
REQ-026 SHALL instantiate the combinational cipher core Blink_top as its only sub-module; FIFO and FSM SHALL be local.

Verification
REQ-027 SHALL cover round-trip: key=0, tweak=0, encrypt blocks 128'h0 and 128'h0123..EF (in_last on 2nd), then decrypt results -> original blocks returned, out_last on 2nd only.
REQ-028 SHALL cover tweak counter (macro defined): two identical blocks 128'hFF..FF in one message -> two different outputs matching golden Blink_top with idx 0 and 1; macro undefined -> two identical outputs.
REQ-029 SHALL cover wrap: cfg_tweak[63:0]=64'hFFFF_FFFF_FFFF_FFFF -> block 2 uses low tweak 0, upper 192 bits unchanged, matching golden model.
REQ-030 SHALL cover backpressure: out_ready=0, in_valid held -> exactly 4 blocks accepted, in_ready=0 after; out_ready=1 -> 4 outputs in order, then streaming resumes at 1/cycle.
REQ-031 SHALL cover latency/DRAIN: single block with in_last at cycle N, out_ready=1 -> out_valid at N+2, in_ready=0 during DRAIN, busy=0 at N+3.
REQ-032 SHALL cover mid-message reset: rst=0 for one edge with 3 blocks buffered -> out_valid=0, busy=0 next cycle, new message uses newly sampled cfg.
